// File: rtl/spi_slave_fifo.sv
// SPI slave with a TX FIFO feeding MISO and a word-wide RX output.
// The SPI pins are synchronised into the i_Clk domain and all shifting is
// done on detected SPI clock edges, so i_Clk must run at least 8x SCLK.
module spi_slave_fifo #(
  parameter int SPI_MODE  = 0,
  parameter int DATA_LEN  = 16,
  parameter int TX_DEPTH  = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                i_Clk,
  input  logic                i_Rst_L,
  input  logic                i_TX_DV,
  input  logic [DATA_LEN-1:0] i_TX_Data,
  output logic                o_TX_Ready,
  output logic                o_RX_DV,
  output logic [DATA_LEN-1:0] o_RX_Data,
  output logic                o_TX_Underrun,
  output logic                o_Busy,
  input  logic                i_SPI_Clk,
  input  logic                i_SPI_MOSI,
  input  logic                i_SPI_CS_n,
  output logic                o_SPI_MISO
);

  localparam logic CPOL = (SPI_MODE == 2) || (SPI_MODE == 3);
  localparam logic CPHA = (SPI_MODE == 1) || (SPI_MODE == 3);
  localparam int PTR_W = $clog2(TX_DEPTH);
  localparam int CNT_W = $clog2(TX_DEPTH + 1);
  localparam int BIT_W = $clog2(DATA_LEN + 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_LEN - 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(TX_DEPTH);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t state;

  logic [2:0] sclk_sync;
  logic [2:0] cs_sync;
  logic [1:0] mosi_sync;

  logic sclk_s;
  logic sclk_d;
  logic cs_s;
  logic cs_d;
  logic mosi_s;

  logic lead_edge;
  logic trail_edge;
  logic sample_edge;
  logic shift_edge;
  logic cs_fall;

  logic [DATA_LEN-1:0] fifo_mem [TX_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    fifo_count;
  logic [CNT_W-1:0]    count_next;
  logic                fifo_empty;
  logic                wr_en;
  logic                pop_en;
  logic                word_start;
  logic                word_done;
  logic                load_req;
  logic [DATA_LEN-1:0] head_word;

  logic [BIT_W-1:0]    bit_cnt;
  logic [DATA_LEN-1:0] tx_shift;
  logic [DATA_LEN-1:0] tx_next;
  logic [DATA_LEN-1:0] rx_shift;
  logic [DATA_LEN-1:0] rx_next;
  logic                under_pend;
  logic                miso_bit;

  // Two-flop synchronisers on all SPI pins; SCLK and CS_n get a third stage for edge detection
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sclk_sync <= {3{CPOL}};
      cs_sync   <= 3'b111;
      mosi_sync <= 2'b00;
    end else begin
      sclk_sync <= {sclk_sync[1:0], i_SPI_Clk};
      cs_sync   <= {cs_sync[1:0], i_SPI_CS_n};
      mosi_sync <= {mosi_sync[0], i_SPI_MOSI};
    end
  end

  assign sclk_s = sclk_sync[1];
  assign sclk_d = sclk_sync[2];
  assign cs_s   = cs_sync[1];
  assign cs_d   = cs_sync[2];
  assign mosi_s = mosi_sync[1];

  assign lead_edge   = (sclk_d == CPOL) && (sclk_s != CPOL);
  assign trail_edge  = (sclk_d != CPOL) && (sclk_s == CPOL);
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;
  assign cs_fall     = cs_d && !cs_s;

  assign fifo_empty = (fifo_count == '0);
  assign head_word  = fifo_empty ? '0 : fifo_mem[rd_ptr];
  assign wr_en      = i_TX_DV && o_TX_Ready;
  assign word_start = (state == IDLE) && cs_fall;
  assign word_done  = (state == SHIFT) && !cs_s && sample_edge && (bit_cnt == LAST_BIT);
  assign load_req   = word_start || word_done;
  assign pop_en     = load_req && !fifo_empty;

  assign tx_next  = MSB_FIRST ? {tx_shift[DATA_LEN-2:0], 1'b0} : {1'b0, tx_shift[DATA_LEN-1:1]};
  assign rx_next  = MSB_FIRST ? {rx_shift[DATA_LEN-2:0], mosi_s} : {mosi_s, rx_shift[DATA_LEN-1:1]};
  assign miso_bit = MSB_FIRST ? tx_shift[DATA_LEN-1] : tx_shift[0];

  // MISO is released whenever the raw chip select is high so other slaves can drive the bus
  assign o_SPI_MISO = i_SPI_CS_n ? 1'bz : miso_bit;

  // Next FIFO occupancy: a write and a pop in the same cycle cancel out
  always_comb begin
    count_next = fifo_count;
    if (wr_en && !pop_en) begin
      count_next = fifo_count + 1'b1;
    end else if (!wr_en && pop_en) begin
      count_next = fifo_count - 1'b1;
    end
  end

  // FIFO storage has no reset; only entries between the pointers are ever read
  always_ff @(posedge i_Clk) begin
    if (wr_en) begin
      fifo_mem[wr_ptr] <= i_TX_Data;
    end
  end

  // FIFO pointers, occupancy and the registered not-full flag
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      o_TX_Ready <= 1'b1;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      fifo_count <= count_next;
      o_TX_Ready <= (count_next < DEPTH_C);
    end
  end

  // Transfer FSM: word framing, TX/RX shifting and all registered status outputs.
  // A word loaded empty at a word boundary only reports underrun once its first bit
  // is sampled, so a CS_n rise straight after the last word does not flag a bogus underrun.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      tx_shift      <= '0;
      rx_shift      <= '0;
      under_pend    <= 1'b0;
      o_RX_DV       <= 1'b0;
      o_RX_Data     <= '0;
      o_TX_Underrun <= 1'b0;
      o_Busy        <= 1'b0;
    end else begin
      o_RX_DV       <= 1'b0;
      o_TX_Underrun <= 1'b0;
      case (state)
        IDLE: begin
          bit_cnt    <= '0;
          rx_shift   <= '0;
          tx_shift   <= head_word;
          under_pend <= 1'b0;
          o_Busy     <= 1'b0;
          if (cs_fall) begin
            state         <= SHIFT;
            o_Busy        <= 1'b1;
            o_TX_Underrun <= fifo_empty;
          end
        end
        SHIFT: begin
          if (cs_s) begin
            state      <= IDLE;
            o_Busy     <= 1'b0;
            bit_cnt    <= '0;
            under_pend <= 1'b0;
            tx_shift   <= head_word;
          end else if (sample_edge) begin
            rx_shift <= rx_next;
            if (under_pend) begin
              o_TX_Underrun <= 1'b1;
              under_pend    <= 1'b0;
            end
            if (bit_cnt == LAST_BIT) begin
              bit_cnt    <= '0;
              o_RX_Data  <= rx_next;
              o_RX_DV    <= 1'b1;
              tx_shift   <= head_word;
              under_pend <= fifo_empty;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else if (shift_edge && (bit_cnt != '0)) begin
            tx_shift <= tx_next;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_fifo.sv
// Testbench for spi_slave_fifo: five instances (modes 0-3 MSb first, mode 0 LSb
// first) share one SPI master, selected by cur. A queue model of the TX FIFO
// predicts MISO words, underruns and the not-full flag.
module tb_spi_slave_fifo;

  localparam int NI = 5;
  localparam int HP = 8;

  logic        clk;
  logic        rst_n;
  logic        tx_dv;
  logic [15:0] tx_data;
  logic        sclk_m;
  logic        mosi_m;
  logic        csn_m;
  int          cur;

  wire        ready_w  [NI];
  wire        rxdv_w   [NI];
  wire [15:0] rxdata_w [NI];
  wire        undr_w   [NI];
  wire        busy_w   [NI];
  wire        miso_w   [NI];

  int          n_checks;
  int          n_fails;
  int          rx_pulses;
  int          undr_pulses;
  logic [15:0] last_rx;
  logic        first_bit;

  logic [15:0] model_q [$];
  logic [15:0] wr_q    [$];
  logic [15:0] mosi_q  [$];
  logic [15:0] miso_q  [$];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int   MODE = g % 4;
    localparam logic POL  = (MODE >= 2);
    wire miso_l;
    spi_slave_fifo #(
      .SPI_MODE (MODE),
      .DATA_LEN (16),
      .TX_DEPTH (4),
      .MSB_FIRST(g != 4)
    ) u_dut (
      .i_Clk        (clk),
      .i_Rst_L      (rst_n),
      .i_TX_DV      (tx_dv && (cur == g)),
      .i_TX_Data    (tx_data),
      .o_TX_Ready   (ready_w[g]),
      .o_RX_DV      (rxdv_w[g]),
      .o_RX_Data    (rxdata_w[g]),
      .o_TX_Underrun(undr_w[g]),
      .o_Busy       (busy_w[g]),
      .i_SPI_Clk    ((cur == g) ? sclk_m : POL),
      .i_SPI_MOSI   (mosi_m),
      .i_SPI_CS_n   ((cur == g) ? csn_m : 1'b1),
      .o_SPI_MISO   (miso_l)
    );
    assign miso_w[g] = miso_l;
  end

  // Free-running system clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count one-cycle pulses from the selected instance, sampled away from the active edge
  always @(negedge clk) begin
    if (rxdv_w[cur] === 1'b1) begin
      rx_pulses = rx_pulses + 1;
      last_rx   = rxdata_w[cur];
    end
    if (undr_w[cur] === 1'b1) begin
      undr_pulses = undr_pulses + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic mosi_bit_of(input int i);
    int pos;
    pos = (cur != 4) ? 15 - (i % 16) : (i % 16);
    if (i / 16 >= mosi_q.size()) return 1'b0;
    return mosi_q[i / 16][pos];
  endfunction

  task automatic resetDut(input int new_cur);
    @(negedge clk);
    rst_n  = 1'b0;
    tx_dv  = 1'b0;
    csn_m  = 1'b1;
    cur    = new_cur;
    sclk_m = ((new_cur % 4) >= 2);
    mosi_m = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    model_q = {};
  endtask

  // Back-to-back writes of wr_q; the model accepts a word only while it holds fewer than 4
  task automatic writeWords();
    @(negedge clk);
    foreach (wr_q[k]) begin
      tx_dv   = 1'b1;
      tx_data = wr_q[k];
      if (model_q.size() < 4) model_q.push_back(wr_q[k]);
      @(negedge clk);
    end
    tx_dv = 1'b0;
    @(negedge clk);
  endtask

  // SPI master: clocks nbits from mosi_q and captures MISO into miso_q
  task automatic applyStimulus(input int nbits, input bit hold_cs);
    logic        pol;
    logic        pha;
    logic        captured;
    logic [15:0] cw;
    int          pos;
    pol = ((cur % 4) >= 2);
    pha = ((cur % 4) == 1) || ((cur % 4) == 3);
    miso_q = {};
    cw = '0;
    @(negedge clk);
    sclk_m = pol;
    csn_m  = 1'b0;
    if (!pha) mosi_m = mosi_bit_of(0);
    repeat (HP) @(negedge clk);
    checkOutput($sformatf("busy mode %0d", cur), {31'd0, busy_w[cur]}, 32'd1);
    for (int i = 0; i < nbits; i++) begin
      if (!pha) begin
        sclk_m   = ~pol;
        captured = miso_w[cur];
        repeat (HP) @(negedge clk);
        sclk_m = pol;
        if (i + 1 < nbits) mosi_m = mosi_bit_of(i + 1);
        repeat (HP) @(negedge clk);
      end else begin
        sclk_m = ~pol;
        mosi_m = mosi_bit_of(i);
        repeat (HP) @(negedge clk);
        sclk_m   = pol;
        captured = miso_w[cur];
        repeat (HP) @(negedge clk);
      end
      if (i == 0) first_bit = captured;
      pos = (cur != 4) ? 15 - (i % 16) : (i % 16);
      cw[pos] = captured;
      if ((i % 16) == 15) begin
        miso_q.push_back(cw);
        cw = '0;
      end
    end
    if (!hold_cs) begin
      csn_m = 1'b1;
      repeat (2 * HP) @(negedge clk);
    end
  endtask

  // Full-word transfer of mosi_q with MISO words and pulse counts predicted by the model
  task automatic runTransfer(input string tag);
    logic [15:0] exp_q [$];
    int          exp_under;
    int          rx0;
    int          un0;
    int          n;
    n = mosi_q.size();
    exp_under = 0;
    for (int w = 0; w < n; w++) begin
      if (model_q.size() > 0) begin
        exp_q.push_back(model_q.pop_front());
      end else begin
        exp_q.push_back(16'h0000);
        exp_under++;
      end
    end
    rx0 = rx_pulses;
    un0 = undr_pulses;
    applyStimulus(n * 16, 1'b0);
    for (int w = 0; w < n; w++) begin
      checkOutput($sformatf("%s miso word %0d", tag, w), {16'd0, miso_q[w]}, {16'd0, exp_q[w]});
    end
    checkOutput($sformatf("%s rx pulses", tag), rx_pulses - rx0, n);
    checkOutput($sformatf("%s last rx", tag), {16'd0, last_rx}, {16'd0, mosi_q[n-1]});
    checkOutput($sformatf("%s rx data", tag), {16'd0, rxdata_w[cur]}, {16'd0, mosi_q[n-1]});
    checkOutput($sformatf("%s underruns", tag), undr_pulses - un0, exp_under);
    checkOutput($sformatf("%s busy after", tag), {31'd0, busy_w[cur]}, 32'd0);
  endtask

  initial begin
    int rx0;
    int nw;
    int nx;
    int mode;
    n_checks    = 0;
    n_fails     = 0;
    rx_pulses   = 0;
    undr_pulses = 0;
    last_rx     = '0;
    first_bit   = 1'b0;
    cur     = 0;
    rst_n   = 1'b0;
    tx_dv   = 1'b0;
    tx_data = '0;
    sclk_m  = 1'b0;
    mosi_m  = 1'b0;
    csn_m   = 1'b1;

    // Reset values
    repeat (2) @(negedge clk);
    checkOutput("reset ready", {31'd0, ready_w[0]}, 32'd1);
    checkOutput("reset rx_dv", {31'd0, rxdv_w[0]}, 32'd0);
    checkOutput("reset rx_data", {16'd0, rxdata_w[0]}, 32'd0);
    checkOutput("reset underrun", {31'd0, undr_w[0]}, 32'd0);
    checkOutput("reset busy", {31'd0, busy_w[0]}, 32'd0);
    rst_n = 1'b1;

    // Single word in every mode
    for (int m = 0; m < 4; m++) begin
      resetDut(m);
      wr_q = {16'hA5C3};
      writeWords();
      mosi_q = {16'h1234};
      runTransfer($sformatf("mode%0d single", m));
    end

    // Three words back to back under one CS_n
    resetDut(0);
    wr_q = {16'h0001, 16'h0002, 16'h0003};
    writeWords();
    mosi_q = {16'($urandom), 16'($urandom), 16'($urandom)};
    runTransfer("three words");

    // Overfill the FIFO, then drain one word past its contents
    resetDut(0);
    wr_q = {};
    for (int k = 0; k < 5; k++) wr_q.push_back(16'($urandom_range(1, 16'hFFFF)));
    writeWords();
    checkOutput("full ready", {31'd0, ready_w[0]}, 32'd0);
    mosi_q = {};
    for (int k = 0; k < 5; k++) mosi_q.push_back(16'($urandom));
    runTransfer("overflow");

    // CS_n raised after 9 bits discards the partial word and its TX word
    resetDut(0);
    wr_q = {16'($urandom), 16'($urandom)};
    writeWords();
    mosi_q = {16'($urandom)};
    rx0 = rx_pulses;
    applyStimulus(9, 1'b1);
    csn_m = 1'b1;
    repeat (2 * HP) @(negedge clk);
    checkOutput("abort rx pulses", rx_pulses - rx0, 0);
    checkOutput("abort rx data", {16'd0, rxdata_w[0]}, 32'd0);
    checkOutput("abort busy", {31'd0, busy_w[0]}, 32'd0);
    void'(model_q.pop_front());
    mosi_q = {16'hBEEF};
    runTransfer("after abort");

    // Randomised rounds across the four modes
    for (int r = 0; r < 8; r++) begin
      mode = $urandom_range(0, 3);
      resetDut(mode);
      nw = $urandom_range(0, 6);
      wr_q = {};
      for (int k = 0; k < nw; k++) wr_q.push_back(16'($urandom));
      writeWords();
      checkOutput($sformatf("rand%0d ready", r), {31'd0, ready_w[cur]},
                  (model_q.size() < 4) ? 32'd1 : 32'd0);
      nx = $urandom_range(1, 5);
      mosi_q = {};
      for (int k = 0; k < nx; k++) mosi_q.push_back(16'($urandom));
      runTransfer($sformatf("rand%0d", r));
    end

    // LSb-first instance, then reset in the middle of a word
    resetDut(4);
    wr_q = {16'h0001};
    writeWords();
    mosi_q = {16'($urandom)};
    runTransfer("lsb first");
    checkOutput("lsb first bit", {31'd0, first_bit}, 32'd1);
    wr_q = {16'($urandom)};
    writeWords();
    mosi_q = {16'($urandom)};
    rx0 = rx_pulses;
    applyStimulus(7, 1'b1);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset ready", {31'd0, ready_w[4]}, 32'd1);
    checkOutput("midreset rx_dv", {31'd0, rxdv_w[4]}, 32'd0);
    checkOutput("midreset rx_data", {16'd0, rxdata_w[4]}, 32'd0);
    checkOutput("midreset underrun", {31'd0, undr_w[4]}, 32'd0);
    checkOutput("midreset busy", {31'd0, busy_w[4]}, 32'd0);
    csn_m  = 1'b1;
    sclk_m = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("midreset rx pulses", rx_pulses - rx0, 0);
    model_q = {};
    wr_q = {16'($urandom)};
    writeWords();
    mosi_q = {16'($urandom)};
    runTransfer("resume");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
